product_accumulator: RTL and testbench
======================================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL provide parameter ACC_W, default 12: accumulator width in bits; legal range 9..15.
REQ-002 SHALL provide parameter CNT_W, default 5: beat-counter width; frame auto-closes at 2^CNT_W beats.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: upstream 8-bit product present on in_prod.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept a product this cycle.
REQ-007 SHALL have port in_prod, input, 8 bits: unsigned product from the 4x4 array multiplier.
REQ-008 SHALL have port in_last, input, 1 bit: qualified by in_valid; marks the final product of a frame.
REQ-009 SHALL have port out_valid, output, 1 bit: out_byte holds a result byte.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts out_byte this cycle.
REQ-011 SHALL have port out_byte, output, 8 bits: result byte, low byte first, then high byte.
REQ-012 SHALL have port out_hi, output, 1 bit: 1 when out_byte is the high byte.
REQ-013 SHALL have port ovf, output, 1 bit: sticky overflow flag for the current or last frame.

Function
REQ-014 SHALL implement states IDLE, ACC, SEND_LO, SEND_HI; a beat is accepted when in_valid and in_ready are both 1.
REQ-015 SHALL drive in_ready=1 in IDLE and ACC, 0 in SEND_LO and SEND_HI; in_valid in SEND states is ignored and nothing is accepted.
REQ-016 SHALL, on a beat in IDLE, load acc with in_prod zero-extended, clear ovf, set beat count to 1, and enter ACC.
REQ-017 SHALL, on a beat in ACC, set acc to (acc + zero-extended in_prod) mod 2^ACC_W and increment beat count.
REQ-018 SHALL set ovf when an ACC-state addition carries out of bit ACC_W-1; ovf stays set until the next frame's first beat or reset.
REQ-019 SHALL leave IDLE or ACC for SEND_LO on the beat carrying in_last=1, or on the beat that brings the count to 2^CNT_W.
REQ-020 SHALL close a single-beat frame (in_last on the IDLE beat) with acc=in_prod and ovf=0.
REQ-021 SHALL assert out_valid in the cycle after the closing beat (latency 1), and hold it in SEND_LO and SEND_HI only.
REQ-022 SHALL drive out_byte=acc[7:0], out_hi=0 in SEND_LO.
REQ-023 SHALL drive in SEND_HI out_hi=1 and out_byte bit 7=ovf, bits 6..ACC_W-8 zero, bits ACC_W-9..0 = acc[ACC_W-1:8].
REQ-024 SHALL hold out_byte, out_hi and out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL move SEND_LO->SEND_HI on out_ready=1, and SEND_HI->IDLE on out_ready=1; in_ready returns to 1 the cycle after the SEND_HI handshake.
REQ-026 SHALL keep acc and ovf unchanged in IDLE until the next frame's first beat; they are not cleared on SEND_HI exit.
REQ-027 SHALL drive out_byte=0 and out_hi=0 whenever out_valid=0.

Reset
REQ-028 SHALL, while rst=1 at a clock edge, enter IDLE and set acc=0, beat count=0 and ovf=0, from any state.
REQ-029 SHALL hold out_valid=0 and in_ready=1 in the cycle after reset, and discard any partial frame or unsent result.
REQ-030 SHALL give rst priority over a simultaneous input or output handshake.

Verification
REQ-031 SHALL cover reset: rst for 2 cycles -> out_valid=0, in_ready=1, ovf=0, out_byte=0x00.
REQ-032 SHALL cover a basic frame: products 15, 20, 225, last on 225, out_ready=1 -> bytes 0x04 (out_hi=0), then 0x01 (out_hi=1), ovf=0.
REQ-033 SHALL cover backpressure: the same frame with out_ready=0 for 5 cycles -> 0x04 held stable for all 5 cycles, in_ready=0, then 0x04 and 0x01 delivered in order.
REQ-034 SHALL cover overflow: 19 beats of 225, last on the 19th -> sum 4275 wraps to 179 -> bytes 0xB3, then 0x80, ovf=1.
REQ-035 SHALL cover auto-close: 32 beats of value 1, in_last=0 throughout -> SEND_LO after beat 32, bytes 0x20 then 0x00; a 33rd in_valid is not accepted until IDLE.
REQ-036 SHALL cover mid-frame reset: rst after 3 beats -> then a single beat 0x09 with last -> bytes 0x09 then 0x00, with no residue from the aborted frame.

Source files
------------

// File: rtl/product_accumulator.sv
// Accumulates a frame of 8-bit multiplier products into an ACC_W-bit sum with a
// sticky overflow flag, then returns the result as two bytes: low first, then high.
module product_accumulator #(
  parameter int ACC_W = 12,
  parameter int CNT_W = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_prod,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic       out_hi,
  output logic       ovf
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends combinationally on ready, and payload is held while valid && !ready.
  typedef enum logic [1:0] {IDLE, ACC, SEND_LO, SEND_HI} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q;
  logic               beat;
  logic               cnt_full;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W:0]     sum;
  logic [ACC_W-1:0]   acc_hi;

  assign in_ready  = (state_q == IDLE) || (state_q == ACC);
  assign out_valid = (state_q == SEND_LO) || (state_q == SEND_HI);
  assign beat      = in_valid && in_ready;
  assign prod_ext  = {{(ACC_W-8){1'b0}}, in_prod};
  assign sum       = {1'b0, acc_q} + {1'b0, prod_ext};
  // Count saturating at all-ones means this beat is number 2^CNT_W.
  assign cnt_full  = (cnt_q == '1);
  assign acc_hi    = acc_q >> 8;
  assign ovf       = ovf_q;

  always_comb begin
    state_d  = state_q;
    out_byte = 8'h00;
    out_hi   = 1'b0;
    case (state_q)
      IDLE: begin
        if (beat) state_d = in_last ? SEND_LO : ACC;
      end
      ACC: begin
        if (beat && (in_last || cnt_full)) state_d = SEND_LO;
      end
      SEND_LO: begin
        out_byte = acc_q[7:0];
        if (out_ready) state_d = SEND_HI;
      end
      SEND_HI: begin
        out_hi   = 1'b1;
        out_byte = {ovf_q, acc_hi[6:0]};
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (beat) begin
        if (state_q == IDLE) begin
          acc_q <= prod_ext;
          cnt_q <= CNT_W'(1);
          ovf_q <= 1'b0;
        end else begin
          acc_q <= sum[ACC_W-1:0];
          cnt_q <= cnt_q + CNT_W'(1);
          if (sum[ACC_W]) ovf_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: a table of frames with hand-computed
// result bytes, plus sequences for reset, backpressure and send-phase blocking.
module tb_product_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_prod;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_byte;
  logic       out_hi;
  logic       ovf;

  int total = 0;
  int bad   = 0;

  product_accumulator #(.ACC_W(12), .CNT_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_prod  (in_prod),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_byte (out_byte),
    .out_hi   (out_hi),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string          name;
    logic [3:0][7:0] prods;   // beat i uses prods[min(i,3)]
    int             n_beats;
    logic           last;
    logic [7:0]     exp_lo;
    logic [7:0]     exp_hi;
    logic           exp_ovf;
  } frame_t;

  frame_t vec[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_beat(input logic [7:0] p, input logic l);
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_prod  = 8'h00;
    in_last  = 1'b0;
  endtask

  task automatic drive_frame(input frame_t f);
    for (int i = 0; i < f.n_beats; i++)
      drive_beat(f.prods[(i > 3) ? 3 : i], f.last && (i == f.n_beats - 1));
  endtask

  // Called one cycle after the closing beat; drains both bytes with out_ready=1.
  task automatic collect(input string name, input logic [7:0] lo, input logic [7:0] hi,
                         input logic exp_ovf);
    check({name, " lo valid"}, out_valid, 1);
    check({name, " lo out_hi"}, out_hi, 0);
    check({name, " lo byte"}, out_byte, lo);
    check({name, " in_ready busy"}, in_ready, 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({name, " hi valid"}, out_valid, 1);
    check({name, " hi out_hi"}, out_hi, 1);
    check({name, " hi byte"}, out_byte, hi);
    check({name, " ovf"}, ovf, exp_ovf);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({name, " idle valid"}, out_valid, 0);
    check({name, " idle byte"}, out_byte, 0);
    check({name, " idle in_ready"}, in_ready, 1);
    check({name, " ovf kept"}, ovf, exp_ovf);
  endtask

  initial begin
    vec[0] = '{"basic",      {8'd225, 8'd225, 8'd20,  8'd15},  3,  1'b1, 8'h04, 8'h01, 1'b0};
    vec[1] = '{"mixed",      {8'd7,   8'd50,  8'd100, 8'd200}, 4,  1'b1, 8'h65, 8'h01, 1'b0};
    vec[2] = '{"max_no_ovf", {8'd255, 8'd255, 8'd255, 8'd255}, 16, 1'b1, 8'hF0, 8'h0F, 1'b0};
    vec[3] = '{"first_ovf",  {8'd255, 8'd255, 8'd255, 8'd255}, 17, 1'b1, 8'hEF, 8'h80, 1'b1};
    vec[4] = '{"ovf_19",     {8'd225, 8'd225, 8'd225, 8'd225}, 19, 1'b1, 8'hB3, 8'h80, 1'b1};
    vec[5] = '{"ovf_clear",  {8'd225, 8'd225, 8'd20,  8'd15},  3,  1'b1, 8'h04, 8'h01, 1'b0};
    vec[6] = '{"auto_close", {8'd1,   8'd1,   8'd1,   8'd1},   32, 1'b0, 8'h20, 8'h00, 1'b0};
    vec[7] = '{"single",     {8'd9,   8'd9,   8'd9,   8'd9},   1,  1'b1, 8'h09, 8'h00, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_prod = 8'h00; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset out_valid", out_valid, 0);
    check("reset in_ready", in_ready, 1);
    check("reset ovf", ovf, 0);
    check("reset out_byte", out_byte, 0);
    check("reset out_hi", out_hi, 0);

    for (int k = 0; k < 8; k++) begin
      drive_frame(vec[k]);
      collect(vec[k].name, vec[k].exp_lo, vec[k].exp_hi, vec[k].exp_ovf);
    end

    // Backpressure: low byte held for 5 stalled cycles, inputs blocked.
    drive_frame(vec[0]);
    for (int c = 0; c < 5; c++) begin
      check("bp valid", out_valid, 1);
      check("bp byte", out_byte, 8'h04);
      check("bp out_hi", out_hi, 0);
      check("bp in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    collect("bp", 8'h04, 8'h01, 1'b0);

    // Auto-close then a pending 33rd beat that must wait until IDLE.
    drive_frame(vec[6]);
    in_valid = 1'b1; in_prod = 8'd5; in_last = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check("ac33 in_ready", in_ready, 0);
      check("ac33 byte held", out_byte, 8'h20);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("ac33 hi byte", out_byte, 8'h00);
    check("ac33 hi flag", out_hi, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("ac33 idle in_ready", in_ready, 1);
    check("ac33 idle valid", out_valid, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_prod = 8'h00; in_last = 1'b0;
    collect("ac33 late beat", 8'h05, 8'h00, 1'b0);

    // Mid-frame reset after an overflowing frame, reset racing a beat.
    drive_frame(vec[4]);
    collect("pre_rst", 8'hB3, 8'h80, 1'b1);
    drive_beat(8'd200, 1'b0);
    drive_beat(8'd200, 1'b0);
    drive_beat(8'd200, 1'b0);
    rst = 1'b1; in_valid = 1'b1; in_prod = 8'd77; in_last = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0; in_prod = 8'h00; in_last = 1'b0;
    check("mid_rst valid", out_valid, 0);
    check("mid_rst in_ready", in_ready, 1);
    check("mid_rst ovf", ovf, 0);
    drive_beat(8'h09, 1'b1);
    collect("mid_rst single", 8'h09, 8'h00, 1'b0);

    // Reset while the low byte is waiting discards the result.
    drive_frame(vec[1]);
    rst = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; out_ready = 1'b0;
    check("send_rst valid", out_valid, 0);
    check("send_rst byte", out_byte, 0);
    check("send_rst in_ready", in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
